nco_sym_gen: RTL and testbench

Parametrised successor to the team's sine/cosine/average generator. A phase-accumulator NCO drives a full-period sine ROM. It produces offset-binary sine and cosine outputs plus a moving-average output. The `dataeve`/`dataodd` symbol bits select a quadrant phase offset, and symbol changes are applied only at accumulator wrap. The block feeds the DAC/test-output path in place of the fixed-frequency generator.

---
 rtl/sin_gen_pkg.sv | 39 +++
 rtl/sine_rom.sv | 35 +++
 rtl/nco_sym_gen.sv | 81 ++++++++
 tb/tb_nco_sym_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sin_gen_pkg.sv
// Shared constants and elaboration-time helpers for the sine generators:
// quadrant offset mapping and sine ROM contents.
package sin_gen_pkg;

  localparam int MID = 128;

  typedef enum logic [1:0] {
    SYM_Q0   = 2'd0,
    SYM_Q90  = 2'd1,
    SYM_Q180 = 2'd2,
    SYM_Q270 = 2'd3
  } sym_e;

  function automatic int mid_of(input int data_w);
    return 1 << (data_w - 1);
  endfunction

  // {dataodd,dataeve} -> quadrant offset in ROM index units
  function automatic int sym_off(input logic [1:0] sym, input int lut_aw);
    case (sym_e'(sym))
      SYM_Q0:   return 0;
      SYM_Q90:  return 1 << (lut_aw - 2);
      SYM_Q180: return 2 << (lut_aw - 2);
      default:  return 3 << (lut_aw - 2);
    endcase
  endfunction

  // Offset-binary sine sample, rounded half away from zero
  function automatic int lut_val(input int k, input int data_w, input int lut_aw);
    real amp;
    real x;
    int  r;
    amp = real'((1 << (data_w - 1)) - 1);
    x   = amp * $sin(2.0 * 3.14159265358979 * real'(k) / real'(1 << lut_aw));
    r   = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    return mid_of(data_w) + r;
  endfunction

endpackage

// File: rtl/sine_rom.sv
// Full-period sine ROM with two registered read ports (sine and cosine index).
module sine_rom
  import sin_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LUT_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LUT_AW-1:0] sin_idx,
  input  logic [LUT_AW-1:0] cos_idx,
  output logic [DATA_W-1:0] sin_q,
  output logic [DATA_W-1:0] cos_q
);
  localparam int N = 1 << LUT_AW;

  logic [DATA_W-1:0] lut [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam logic [DATA_W-1:0] V = DATA_W'(lut_val(k, DATA_W, LUT_AW));
    assign lut[k] = V;
  end

  // Reset presents phase 0: sine at midscale, cosine at full positive
  always_ff @(posedge clk) begin
    if (reset) begin
      sin_q <= DATA_W'(mid_of(DATA_W));
      cos_q <= '1;
    end else if (en) begin
      sin_q <= lut[sin_idx];
      cos_q <= lut[cos_idx];
    end
  end
endmodule

// File: rtl/nco_sym_gen.sv
// Phase-accumulator NCO with quadrant symbol offset applied at accumulator
// wrap, sine/cosine ROM outputs and a moving average of the sine output.
module nco_sym_gen
  import sin_gen_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int LUT_AW   = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ACC_W-1:0]  fcw,
  input  logic              dataeve,
  input  logic              dataodd,
  output logic [DATA_W-1:0] sineout,
  output logic [DATA_W-1:0] cosout,
  output logic [DATA_W-1:0] avgout,
  output logic              sym_applied
);
  localparam int W     = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam logic [DATA_W-1:0] MID_V = DATA_W'(mid_of(DATA_W));
  localparam logic [LUT_AW-1:0] QTR   = LUT_AW'(1 << (LUT_AW - 2));

  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    acc_nxt;
  logic              wrap;
  logic [LUT_AW-1:0] off;
  logic [LUT_AW-1:0] off_new;
  logic [LUT_AW-1:0] sin_idx;
  logic [LUT_AW-1:0] cos_idx;

  assign acc_nxt = {1'b0, acc} + {1'b0, fcw};
  assign wrap    = acc_nxt[ACC_W];
  assign off_new = LUT_AW'(sym_off({dataodd, dataeve}, LUT_AW));
  assign sin_idx = acc[ACC_W-1 -: LUT_AW] + off;
  assign cos_idx = sin_idx + QTR;

  // Symbol inputs are only looked at on the wrap cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      off         <= '0;
      sym_applied <= 1'b0;
    end else if (en) begin
      acc         <= acc_nxt[ACC_W-1:0];
      sym_applied <= wrap && (off_new != off);
      if (wrap) off <= off_new;
    end else begin
      sym_applied <= 1'b0;
    end
  end

  sine_rom #(.DATA_W(DATA_W), .LUT_AW(LUT_AW)) u_rom (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sin_idx (sin_idx),
    .cos_idx (cos_idx),
    .sin_q   (sineout),
    .cos_q   (cosout)
  );

  logic [W-1:0][DATA_W-1:0] hist;
  logic [SUM_W-1:0]         sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < W; i++) hist[i] <= MID_V;
      sum <= SUM_W'(MID_V) << AVG_LOG2;
    end else if (en) begin
      hist[0] <= sineout;
      for (int i = 1; i < W; i++) hist[i] <= hist[i-1];
      sum <= sum + SUM_W'(sineout) - SUM_W'(hist[W-1]);
    end
  end

  assign avgout = sum[SUM_W-1:AVG_LOG2];
endmodule

// File: tb/tb_nco_sym_gen.sv
// Bench for nco_sym_gen: reference-model scoreboard plus per-scenario checks.
module tb_nco_sym_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] fcw = '0;
  logic        dataeve = 1'b0;
  logic        dataodd = 1'b0;
  logic [7:0]  sineout, cosout, avgout;
  logic        sym_applied;

  nco_sym_gen dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .fcw         (fcw),
    .dataeve     (dataeve),
    .dataodd     (dataodd),
    .sineout     (sineout),
    .cosout      (cosout),
    .avgout      (avgout),
    .sym_applied (sym_applied)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
    int a;
    int p;
  } exp_t;

  exp_t sbq[$];
  exp_t sb_e;
  int   total = 0;
  int   bad = 0;

  int blut [256];
  int m_acc, m_off, m_sin, m_cos, m_p;
  int m_hist [4];

  function automatic int ref_sin(input int k);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0);
    return (x >= 0.0) ? 128 + $rtoi(x + 0.5) : 128 - $rtoi(-x + 0.5);
  endfunction

  // Reference model advances on each driven edge; expected outputs queued
  task automatic tick();
    exp_t e;
    int idx, nacc, noff;
    if (reset) begin
      m_acc = 0; m_off = 0; m_sin = 128; m_cos = 255; m_p = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 128;
    end else if (en) begin
      idx = ((m_acc >> 8) + m_off) % 256;
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_sin;
      m_sin = blut[idx];
      m_cos = blut[(idx + 64) % 256];
      nacc = m_acc + int'(fcw);
      if (nacc >= 65536) begin
        noff = int'({dataodd, dataeve}) * 64;
        m_p = (noff != m_off) ? 1 : 0;
        m_off = noff;
      end else begin
        m_p = 0;
      end
      m_acc = nacc % 65536;
    end else begin
      m_p = 0;
    end
    e.s = m_sin; e.c = m_cos; e.p = m_p;
    e.a = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) >> 2;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      sb_e = sbq.pop_front();
      total++;
      if (int'(sineout) !== sb_e.s || int'(cosout) !== sb_e.c ||
          int'(avgout) !== sb_e.a || int'(sym_applied) !== sb_e.p) begin
        bad++;
        $display("FAIL scoreboard t=%0t got s=%0d c=%0d a=%0d p=%0d want s=%0d c=%0d a=%0d p=%0d",
                 $time, sineout, cosout, avgout, sym_applied, sb_e.s, sb_e.c, sb_e.a, sb_e.p);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({sineout, cosout, avgout, sym_applied} !== {8'd128, 8'd255, 8'd128, 1'b0}) begin
        bad++;
        $display("FAIL reset_vals got %0d/%0d/%0d/%0d want 128/255/128/0",
                 sineout, cosout, avgout, sym_applied);
      end
    end
  endtask

  task automatic test_quarter();
    int qs [4] = '{128, 255, 128, 1};
    int qc [4] = '{255, 128, 1, 128};
    do_reset();
    fcw = 16'h4000; en = 1'b1; {dataodd, dataeve} = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total++;
      if (int'(sineout) !== qs[(i-1)%4] || int'(cosout) !== qc[(i-1)%4]) begin
        bad++;
        $display("FAIL quarter_tone i=%0d got s=%0d c=%0d want s=%0d c=%0d",
                 i, sineout, cosout, qs[(i-1)%4], qc[(i-1)%4]);
      end
      if (i >= 5) begin
        total++;
        if (avgout !== 8'd128) begin
          bad++;
          $display("FAIL quarter_avg i=%0d got %0d want 128", i, avgout);
        end
      end
    end
  endtask

  task automatic test_sweep();
    do_reset();
    fcw = 16'h0100; en = 1'b1; {dataodd, dataeve} = 2'b00;
    for (int i = 1; i <= 321; i++) begin
      tick();
      if (i == 65 || i == 321) begin
        total++;
        if (sineout !== 8'd255) begin
          bad++;
          $display("FAIL sweep_peak i=%0d got %0d want 255", i, sineout);
        end
      end
      if (i == 193) begin
        total++;
        if (sineout !== 8'd1) begin
          bad++;
          $display("FAIL sweep_trough i=%0d got %0d want 1", i, sineout);
        end
      end
    end
  endtask

  task automatic test_symbol(input logic [1:0] sym, input int p0, input int p1,
                             input int p2, input int p3);
    int pat [4];
    int pulses;
    pat = '{p0, p1, p2, p3};
    pulses = 0;
    do_reset();
    fcw = 16'h4000; en = 1'b1; {dataodd, dataeve} = 2'b00;
    tick();
    tick();
    {dataodd, dataeve} = sym;
    tick();
    total++;
    if (sym_applied !== 1'b0 || sineout !== 8'd128) begin
      bad++;
      $display("FAIL sym_prewrap sym=%0d got p=%0d s=%0d want p=0 s=128", sym, sym_applied, sineout);
    end
    for (int i = 4; i <= 15; i++) begin
      tick();
      if (sym_applied === 1'b1) pulses++;
      if (i >= 5 && i <= 12) begin
        total++;
        if (int'(sineout) !== pat[(i-5)%4]) begin
          bad++;
          $display("FAIL sym_seq sym=%0d i=%0d got %0d want %0d", sym, i, sineout, pat[(i-5)%4]);
        end
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL sym_pulse_count sym=%0d got %0d want 1", sym, pulses);
    end
  endtask

  task automatic test_enable();
    do_reset();
    fcw = 16'h4000; en = 1'b1; {dataodd, dataeve} = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({sineout, cosout, avgout, sym_applied} !== {8'd255, 8'd128, 8'd128, 1'b0}) begin
        bad++;
        $display("FAIL en_hold i=%0d got %0d/%0d/%0d/%0d want 255/128/128/0",
                 i, sineout, cosout, avgout, sym_applied);
      end
    end
    en = 1'b1;
    tick();
    total++;
    if (sineout !== 8'd128) begin
      bad++;
      $display("FAIL en_resume0 got %0d want 128", sineout);
    end
    tick();
    total++;
    if (sineout !== 8'd1) begin
      bad++;
      $display("FAIL en_resume1 got %0d want 1", sineout);
    end
  endtask

  task automatic test_zero_fcw();
    do_reset();
    fcw = 16'h0000; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {dataodd, dataeve} = 2'(i);
      tick();
      total++;
      if ({sineout, cosout, avgout, sym_applied} !== {8'd128, 8'd255, 8'd128, 1'b0}) begin
        bad++;
        $display("FAIL zero_fcw i=%0d got %0d/%0d/%0d/%0d want 128/255/128/0",
                 i, sineout, cosout, avgout, sym_applied);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fcw = 16'h4000; en = 1'b1; {dataodd, dataeve} = 2'b11;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    total++;
    if ({sineout, cosout, avgout, sym_applied} !== {8'd128, 8'd255, 8'd128, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got %0d/%0d/%0d/%0d want 128/255/128/0",
               sineout, cosout, avgout, sym_applied);
    end
    reset = 1'b0;
    tick();
    total++;
    if (sineout !== 8'd128 || cosout !== 8'd255) begin
      bad++;
      $display("FAIL reset_restart0 got s=%0d c=%0d want s=128 c=255", sineout, cosout);
    end
    tick();
    total++;
    if (sineout !== 8'd255 || cosout !== 8'd128) begin
      bad++;
      $display("FAIL reset_restart1 got s=%0d c=%0d want s=255 c=128", sineout, cosout);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) blut[k] = ref_sin(k);
    m_acc = 0; m_off = 0; m_sin = 128; m_cos = 255; m_p = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 128;
    test_reset();
    test_quarter();
    test_sweep();
    test_symbol(2'b10, 128, 1, 128, 255);
    test_symbol(2'b01, 255, 128, 1, 128);
    test_symbol(2'b11, 1, 128, 255, 128);
    test_enable();
    test_zero_fcw();
    test_reset_mid();
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
